b12_trace_monitor: RTL and testbench
====================================

// Module: b12_trace_monitor
// PURPOSE
//  Downstream observer for the b12 game core: samples nloss/nl/speaker each cycle, logs
//  timestamped change events into an internal FIFO, and drains them over a valid/ready port.
//  Compresses the toggling speaker into a per-event toggle count.
//  Sits beside the concolic stimulus player, gated by the same __obs bit, so runs produce compact traces.
// PARAMETERS
//  DEPTH  16  FIFO entries; power of two, >=4
//  TS_W   16  timestamp counter width
// PORTS
//  clock      in   1               single clock, rising edge
//  reset      in   1               synchronous, active-high
//  obs_en     in   1               __obs; logging enable
//  nloss      in   1               DUT output
//  nl         in   4               DUT output
//  speaker    in   1               DUT output
//  out_valid  out  1               FIFO head valid
//  out_ready  in   1               consumer accepts head
//  out_data   out  TS_W+15         {kind[1:0], ts[TS_W-1:0], aux[7:0], nloss, nl[3:0]}
//  fill       out  $clog2(DEPTH)+1 current FIFO occupancy
// BEHAVIOUR
//  Reset (sync, high): FIFO empty, out_valid=0, out_data=0, fill=0, ts=0, spk_cnt=0,
//   drop_cnt=0, prev regs=0, armed=0. Reset mid-run discards all queued entries.
//  ts: free-running counter, +1 every cycle, wraps all-ones->0, independent of obs_en.
//  kind: 00 SNAP, 01 CHANGE, 10 WRAP, 11 DROP (entry encodings in package).
//  Candidates per cycle; at most one push per cycle; priority DROP > SNAP > CHANGE > WRAP:
//   SNAP   first cycle with obs_en=1 after reset (armed=0); sets armed=1.
//   CHANGE obs_en=1, armed=1, {nloss,nl} != {prev_nloss,prev_nl}.
//   WRAP   ts == all-ones this cycle (entry carries ts=all-ones); obs_en ignored.
//   DROP   drop_cnt != 0 and FIFO not full; aux=drop_cnt; clears drop_cnt.
//  Entry fields: ts = current ts; {nloss,nl} = current inputs; aux = spk_cnt for
//   SNAP/CHANGE/WRAP; spk_cnt clears on any accepted non-DROP push.
//  spk_cnt: +1 per cycle with obs_en=1 and speaker != prev_speaker; saturates at 255.
//  prev_nloss/prev_nl/prev_speaker update every cycle regardless of obs_en or push.
//  Lost candidates: one that loses priority, or any push while FULL, adds 1 to drop_cnt
//   (saturate 255). Full is evaluated before this cycle's pop; a pop does not free
//   space for a same-cycle push.
//  Simultaneous push+pop when not full/empty: both occur; fill unchanged.
//  Read: out_data is FIFO head, stable while out_valid=1 && out_ready=0;
//   pop on out_valid && out_ready. Push to an empty FIFO is visible next cycle (1-cycle latency).
//  Pop when empty: ignored. fill range 0..DEPTH.
// STRUCTURE
//  conc_trace_pkg: KIND_SNAP/CHANGE/WRAP/DROP constants, ENTRY_W function of TS_W,
//   field offsets for kind/ts/aux/nl.
//  Sub-module conc_sync_fifo #(WIDTH,DEPTH): registered-head sync FIFO with
//   push/pop/full/empty/count. Top holds ts, prev regs, spk_cnt, drop_cnt, arbiter.
// TESTING
//  T1 reset, obs_en=1, nl=4'h3 held, out_ready=1 -> first entry SNAP ts=1 nl=3 aux=0; no more until change.
//  T2 nl 3->5 at ts=20, speaker toggling 6 times before -> CHANGE ts=20 nl=5 aux=6.
//  T3 out_ready=0, DEPTH+3 nl changes -> fill=DEPTH; release -> DEPTH entries then DROP aux=3.
//  T4 TS_W=4, no changes -> WRAP at ts=15, every 16 cycles; obs_en=0 still yields WRAP.
//  T5 change coincides with pending DROP -> DROP pushed, next DROP aux=1 follows.
//  T6 reset asserted with 5 queued entries -> next cycle out_valid=0, fill=0, then SNAP ts=1.

Source files
------------

// File: rtl/conc_trace_pkg.sv
// Shared entry encoding for the b12 trace monitor: event kinds and field layout
// of a FIFO entry {kind, ts, aux, nloss, nl}.
package conc_trace_pkg;

  typedef enum logic [1:0] {
    KIND_SNAP   = 2'b00,
    KIND_CHANGE = 2'b01,
    KIND_WRAP   = 2'b10,
    KIND_DROP   = 2'b11
  } kind_e;

  localparam int AUX_W     = 8;
  localparam int NL_OFF    = 0;
  localparam int NLOSS_OFF = 4;
  localparam int AUX_OFF   = 5;
  localparam int TS_OFF    = AUX_OFF + AUX_W;

  function automatic int entry_w(input int ts_w);
    return ts_w + 15;
  endfunction

  function automatic int kind_off(input int ts_w);
    return TS_OFF + ts_w;
  endfunction

endpackage

// File: rtl/conc_sync_fifo.sv
// Synchronous FIFO; head is read straight from the storage registers, so a push
// into an empty FIFO is presented on the cycle after it is written.
module conc_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  // Full blocks the push even when a pop happens in the same cycle.
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/b12_trace_monitor.sv
// Observer for the b12 game core: logs timestamped SNAP/CHANGE/WRAP/DROP events
// into a FIFO drained over a valid/ready port, folding speaker toggles into aux.
module b12_trace_monitor
  import conc_trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int TS_W  = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    obs_en,
  input  logic                    nloss,
  input  logic [3:0]              nl,
  input  logic                    speaker,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [TS_W+14:0]        out_data,
  output logic [$clog2(DEPTH):0]  fill
);

  localparam int EW = entry_w(TS_W);

  logic [TS_W-1:0] ts_q, ts_d, stamp;
  logic            armed_q, armed_d;
  logic            prev_nloss_q, prev_spk_q;
  logic [3:0]      prev_nl_q;
  logic [7:0]      spk_cnt_q, spk_cnt_d, drop_cnt_q, drop_cnt_d;
  logic            snap_c, chg_c, wrap_c, drop_c;
  logic            full, empty, push;
  logic [2:0]      n_cand, n_lost;
  kind_e           kind;
  logic [7:0]      aux;
  logic [EW-1:0]   entry;

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [2:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {6'd0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  // ts_q counts cycles since reset; the stamp of the cycle being sampled is one
  // ahead, so the first cycle after reset is stamped 1.
  always_comb begin
    stamp  = ts_q + TS_W'(1);
    ts_d   = stamp;
    snap_c = obs_en && !armed_q;
    chg_c  = obs_en && armed_q && ({nloss, nl} != {prev_nloss_q, prev_nl_q});
    wrap_c = &stamp;
    drop_c = (drop_cnt_q != 8'd0) && !full;
    n_cand = 3'(snap_c) + 3'(chg_c) + 3'(wrap_c) + 3'(drop_c);
    push   = (n_cand != 3'd0) && !full;
    n_lost = push ? n_cand - 3'd1 : n_cand;

    kind = KIND_WRAP;
    aux  = spk_cnt_q;
    if (drop_c) begin
      kind = KIND_DROP;
      aux  = drop_cnt_q;
    end else if (snap_c) begin
      kind = KIND_SNAP;
    end else if (chg_c) begin
      kind = KIND_CHANGE;
    end

    drop_cnt_d = sat_add8(drop_c ? 8'd0 : drop_cnt_q, n_lost);
    spk_cnt_d  = sat_add8((push && !drop_c) ? 8'd0 : spk_cnt_q,
                          {2'b00, obs_en && (speaker != prev_spk_q)});
    armed_d    = armed_q | obs_en;
    entry      = {kind, stamp, aux, nloss, nl};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ts_q         <= '0;
      armed_q      <= 1'b0;
      prev_nloss_q <= 1'b0;
      prev_nl_q    <= '0;
      prev_spk_q   <= 1'b0;
      spk_cnt_q    <= '0;
      drop_cnt_q   <= '0;
    end else begin
      ts_q         <= ts_d;
      armed_q      <= armed_d;
      prev_nloss_q <= nloss;
      prev_nl_q    <= nl;
      prev_spk_q   <= speaker;
      spk_cnt_q    <= spk_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  conc_sync_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
    .clk_i       (clock),
    .rst_i       (reset),
    .push_i      (push),
    .push_data_i (entry),
    .pop_i       (out_ready),
    .head_o      (out_data),
    .full_o      (full),
    .empty_o     (empty),
    .count_o     (fill)
  );

  assign out_valid = !empty;

endmodule

// File: tb/tb_b12_trace_monitor.sv
// Scoreboard bench for b12_trace_monitor: a cycle-level reference model queues
// expected entries, a negedge monitor pops and compares on every handshake.
module tb_b12_trace_monitor;

  localparam int DEPTH = 8;
  localparam int TS_W  = 8;
  localparam int EW    = TS_W + 15;
  localparam int TSMAX = (1 << TS_W) - 1;

  logic clock = 1'b0;
  logic reset = 1'b1, obs_en = 1'b0, nloss = 1'b0, speaker = 1'b0, out_ready = 1'b0;
  logic [3:0] nl = 4'h0;
  logic out_valid;
  logic [EW-1:0] out_data;
  logic [$clog2(DEPTH):0] fill;

  always #5 clock = ~clock;

  b12_trace_monitor #(.DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .obs_en    (obs_en),
    .nloss     (nloss),
    .nl        (nl),
    .speaker   (speaker),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .fill      (fill)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [EW-1:0] scb[$];
  int exp_fill = 0;

  int m_ts = 0, m_armed = 0, m_pnl = 0, m_ps = 0, m_spk = 0, m_drop = 0, m_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [EW-1:0] mk(input int kind, input int ts, input int aux,
                                       input int nls, input int nlv);
    return (EW'(kind) << (TS_W + 13)) | (EW'(ts) << 13) | (EW'(aux) << 5) |
           (EW'(nls) << 4) | EW'(nlv);
  endfunction

  // Reference model: one call per clock cycle with the inputs for that cycle.
  task automatic model(input bit r, input bit oe, input bit nls, input logic [3:0] nlv,
                       input bit sp, input bit rdy);
    int stamp, cur, n, lost, kind, aux;
    bit snap, chg, wrap, full, drp, pushed;
    if (r) begin
      m_ts = 0; m_armed = 0; m_pnl = 0; m_ps = 0; m_spk = 0; m_drop = 0; m_cnt = 0;
      exp_fill = 0;
      scb.delete();
      return;
    end
    stamp = (m_ts + 1) % (TSMAX + 1);
    cur   = int'(nls) * 16 + int'(nlv);
    snap  = oe && (m_armed == 0);
    chg   = oe && (m_armed != 0) && (cur != m_pnl);
    wrap  = (stamp == TSMAX);
    full  = (m_cnt == DEPTH);
    drp   = (m_drop != 0) && !full;
    n     = int'(snap) + int'(chg) + int'(wrap) + int'(drp);
    pushed = (n > 0) && !full;
    lost  = pushed ? n - 1 : n;
    aux   = m_spk;
    if (drp)       begin kind = 3; aux = m_drop; end
    else if (snap) kind = 0;
    else if (chg)  kind = 1;
    else           kind = 2;
    if (pushed) scb.push_back(mk(kind, stamp, aux, int'(nls), int'(nlv)));
    m_drop = (drp ? 0 : m_drop) + lost;
    if (m_drop > 255) m_drop = 255;
    m_spk = ((pushed && !drp) ? 0 : m_spk) + ((oe && (int'(sp) != m_ps)) ? 1 : 0);
    if (m_spk > 255) m_spk = 255;
    if (oe) m_armed = 1;
    m_pnl = cur;
    m_ps  = int'(sp);
    m_ts  = stamp;
    exp_fill = m_cnt;
    m_cnt = m_cnt + int'(pushed) - ((rdy && m_cnt > 0) ? 1 : 0);
  endtask

  task automatic cyc(input bit r, input bit oe, input bit nls, input logic [3:0] nlv,
                     input bit sp, input bit rdy);
    reset = r; obs_en = oe; nloss = nls; nl = nlv; speaker = sp; out_ready = rdy;
    model(r, oe, nls, nlv, sp, rdy);
    @(posedge clock);
    #1;
  endtask

  // Monitor: checks occupancy every cycle and pops the scoreboard on handshakes.
  always @(negedge clock) begin
    logic [EW-1:0] exp_e;
    if (!reset) begin
      chk("fill", 64'(fill), 64'(exp_fill));
      chk("out_valid", 64'(out_valid), 64'(exp_fill != 0));
      if (out_valid && out_ready) begin
        if (scb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL pop_unexpected: got entry 0x%0h, expected none", out_data);
        end else begin
          exp_e = scb.pop_front();
          chk("entry", 64'(out_data), 64'(exp_e));
        end
      end
    end
  end

  logic [3:0] nlv;
  bit nls, sp, oe, rr, rdy;
  int seen, drop_pos, drop_aux, n_drops, aux_sum, rdy_pct;

  initial begin
    @(posedge clock);
    #1;
    cyc(1, 0, 0, 4'h0, 0, 1);
    chk("reset_valid", 64'(out_valid), 64'(0));
    chk("reset_fill", 64'(fill), 64'(0));
    chk("reset_data", 64'(out_data), 64'(0));

    // T1: SNAP on first enabled cycle, then silence while inputs hold
    cyc(0, 1, 0, 4'h3, 0, 1);
    chk("t1_valid", 64'(out_valid), 64'(1));
    chk("t1_snap", 64'(out_data), 64'(mk(0, 1, 0, 0, 3)));
    for (int s = 2; s <= 19; s++) begin
      sp = (s <= 7) ? ((s % 2) == 0) : 1'b0;
      cyc(0, 1, 0, 4'h3, sp, 1);
    end
    chk("t1_quiet", 64'(out_valid), 64'(0));

    // T2: six speaker toggles then nl 3->5 at stamp 20
    cyc(0, 1, 0, 4'h5, 0, 1);
    chk("t2_valid", 64'(out_valid), 64'(1));
    chk("t2_change", 64'(out_data), 64'(mk(1, 20, 6, 0, 5)));
    nlv = 4'h5;
    cyc(0, 1, 0, nlv, 0, 1);
    cyc(0, 1, 0, nlv, 0, 1);

    // T3: overflow with consumer stalled, then drain
    for (int k = 0; k < DEPTH + 3; k++) begin
      nlv = nlv ^ 4'h3;
      cyc(0, 1, 0, nlv, 0, 0);
    end
    cyc(0, 1, 0, nlv, 0, 0);
    chk("t3_full", 64'(fill), 64'(DEPTH));
    seen = 0; drop_pos = -1; drop_aux = -1;
    for (int k = 0; k < DEPTH + 4; k++) begin
      if (out_valid && drop_pos < 0) begin
        if (out_data[EW-1 -: 2] == 2'b11) begin
          drop_pos = seen;
          drop_aux = int'(out_data[12:5]);
        end else seen++;
      end
      cyc(0, 1, 0, nlv, 0, 1);
    end
    chk("t3_drop_pos", 64'(drop_pos), 64'(DEPTH));
    chk("t3_drop_aux", 64'(drop_aux), 64'(3));

    // T5: a change collides with a pending DROP
    for (int k = 0; k < DEPTH + 1; k++) begin
      nlv = nlv ^ 4'h3;
      cyc(0, 1, 0, nlv, 0, 0);
    end
    cyc(0, 1, 0, nlv, 0, 1);
    nlv = nlv ^ 4'h3;
    cyc(0, 1, 0, nlv, 0, 1);
    n_drops = 0; aux_sum = 0;
    for (int k = 0; k < DEPTH + 6; k++) begin
      if (out_valid && out_data[EW-1 -: 2] == 2'b11) begin
        n_drops++;
        aux_sum += int'(out_data[12:5]);
      end
      cyc(0, 1, 0, nlv, 0, 1);
    end
    chk("t5_drop_count", 64'(n_drops), 64'(2));
    chk("t5_drop_aux_sum", 64'(aux_sum), 64'(2));

    // T6: reset discards queued entries
    for (int k = 0; k < 5; k++) begin
      nlv = nlv ^ 4'h3;
      cyc(0, 1, 0, nlv, 0, 0);
    end
    chk("t6_queued", 64'(fill), 64'(5));
    cyc(1, 1, 0, nlv, 0, 0);
    chk("t6_valid", 64'(out_valid), 64'(0));
    chk("t6_fill", 64'(fill), 64'(0));
    cyc(0, 1, 1, 4'h9, 0, 0);
    chk("t6_snap", 64'(out_data), 64'(mk(0, 1, 0, 1, 9)));

    // T4: WRAP with logging disabled, every 2^TS_W cycles
    cyc(1, 0, 0, 4'h0, 0, 1);
    for (int s = 1; s < TSMAX; s++) cyc(0, 0, 0, 4'h0, 0, 1);
    chk("t4_none", 64'(out_valid), 64'(0));
    cyc(0, 0, 0, 4'h0, 0, 1);
    chk("t4_wrap1", 64'(out_data), 64'(mk(2, TSMAX, 0, 0, 0)));
    for (int s = 0; s <= TSMAX; s++) cyc(0, 0, 0, 4'h0, 0, 1);
    chk("t4_wrap2_valid", 64'(out_valid), 64'(1));
    chk("t4_wrap2", 64'(out_data), 64'(mk(2, TSMAX, 0, 0, 0)));

    // Randomized traffic with bursty back-pressure and rare resets
    nls = 1'b0; nlv = 4'h0; rdy_pct = 50;
    for (int k = 0; k < 2500; k++) begin
      if ((k % 64) == 0) rdy_pct = ($urandom_range(0, 1) == 1) ? 90 : 15;
      rr  = ($urandom_range(0, 299) == 0);
      oe  = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 3) == 0) nlv = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) nls = ~nls;
      sp  = 1'($urandom_range(0, 1));
      rdy = ($urandom_range(0, 99) < rdy_pct);
      cyc(rr, oe, nls, nlv, sp, rdy);
    end
    for (int k = 0; k < DEPTH + 12; k++) cyc(0, 0, nls, nlv, 0, 1);
    chk("final_fill", 64'(fill), 64'(m_cnt));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
